// File: rtl/rv32m_pkg.sv
// RV32M multiply/divide shared definitions.
// Op codes, FSM encoding and decode constant.
package rv32m_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle of the muldiv unit.
// master = issuing pipeline, slave = unit.
interface rv32m_muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            kill;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output start, funct3, src_a, src_b, kill, res_ready,
    input  req_ready, res_valid, result, busy
  );

  modport slave (
    input  start, funct3, src_a, src_b, kill, res_ready,
    output req_ready, res_valid, result, busy
  );
endinterface

// File: rtl/rv32m_muldiv_iter.sv
// One iteration of shift-add multiply or
// restoring shift-subtract divide on acc={hi,lo}.
module rv32m_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] part;
  logic [XLEN:0] diff;

  // mul: add multiplicand on lsb, shift right
  // div: shift left, keep difference if no borrow
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]}
         + (acc[0] ? {1'b0, opnd} : '0);
    part = acc[2*XLEN-1:XLEN-1];
    diff = part - {1'b0, opnd};
    if (is_div) begin
      if (diff[XLEN])
        acc_next = {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One bit per cycle, kill for flush.
module rv32m_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int FAST_DIV0 = 1
) (
  input logic                clk,
  input logic                reset,
  rv32m_muldiv_unit_if.slave bus
);
  import rv32m_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc, acc_step, prod_fix;
  logic [XLEN-1:0]   opnd, result_q;
  logic              qneg, rneg;

  logic [2:0]        f;
  logic              accept;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic              div0, ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   spec_res, fix_res;

  rv32m_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div   (op[2]),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  assign f      = bus.funct3;
  assign accept = bus.start & ~bus.kill
                & (state == S_IDLE);

  // operand magnitudes, signs and special cases
  always_comb begin
    a_sgn = (f == MD_MULH) || (f == MD_MULHSU)
         || (f == MD_DIV)  || (f == MD_REM);
    b_sgn = (f == MD_MULH) || (f == MD_DIV)
         || (f == MD_REM);
    a_neg = a_sgn & bus.src_a[XLEN-1];
    b_neg = b_sgn & bus.src_b[XLEN-1];
    a_mag = a_neg ? -bus.src_a : bus.src_a;
    b_mag = b_neg ? -bus.src_b : bus.src_b;
    div0  = (bus.src_b == '0);
    ovf   = ((f == MD_DIV) || (f == MD_REM))
         && (bus.src_a == MIN_INT)
         && (bus.src_b == '1);
    special = (FAST_DIV0 != 0) && f[2]
           && (div0 || ovf);
    if (div0)
      spec_res = f[1] ? bus.src_a : '1;
    else
      spec_res = f[1] ? '0 : bus.src_a;
  end

  // sign correction and result word select
  always_comb begin
    prod_fix = qneg ? -acc : acc;
    fix_res  = '0;
    unique case (op)
      MD_MUL:
        fix_res = acc[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:
        fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:
        fix_res = qneg ? -acc[XLEN-1:0]
                       : acc[XLEN-1:0];
      default:
        fix_res = rneg ? -acc[2*XLEN-1:XLEN]
                       : acc[2*XLEN-1:XLEN];
    endcase
  end

  // next-state logic, kill overrides everything
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nx = special ? S_DONE : S_BUSY;
      S_BUSY:
        if (cnt == '0) state_nx = S_FIX;
      S_FIX:
        state_nx = S_DONE;
      S_DONE:
        if (bus.res_ready) state_nx = S_IDLE;
    endcase
    if (bus.kill) state_nx = S_IDLE;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // operand latch, iteration and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op       <= '0;
      acc      <= '0;
      opnd     <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      result_q <= '0;
    end else if (!bus.kill) begin
      unique case (state)
        S_IDLE: if (accept) begin
          op   <= f;
          cnt  <= CW'(XLEN-1);
          acc  <= {{XLEN{1'b0}},
                   f[2] ? a_mag : b_mag};
          opnd <= f[2] ? b_mag : a_mag;
          qneg <= (a_neg ^ b_neg)
                & ~(f[2] & div0);
          rneg <= a_neg;
          if (special) result_q <= spec_res;
        end
        S_BUSY: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
        end
        S_FIX:
          result_q <= fix_res;
        S_DONE: ;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.res_valid = (state == S_DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit with a
// result scoreboard fed by the stimulus process.
module tb_rv32m_muldiv_unit;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  rv32m_muldiv_unit_if #(.XLEN(32)) bus ();

  rv32m_muldiv_unit #(
    .XLEN      (32),
    .FAST_DIV0 (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  // monitor: pop and compare on every handshake
  always @(negedge clk) begin
    if (!reset && bus.res_valid && bus.res_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected: got %h expected none",
                 bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result !== e.val) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h",
                   e.name, bus.result, e.val);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready)
      check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic issue(input string name,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp,
                       input int lat);
    int c;
    wait_ready();
    if (lat > 0) begin
      exp_t e;
      e.name = name;
      e.val  = exp;
      sb.push_back(e);
    end
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.src_a  = a;
    bus.src_b  = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.src_a  = $urandom;
    bus.src_b  = $urandom;
    if (lat > 0) begin
      c = 1;
      while (!bus.res_valid && c < 100) begin
        @(posedge clk); #1;
        c++;
      end
      check({name, "_lat"}, c, lat);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.funct3    = 3'd0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.kill      = 1'b0;
    bus.res_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue("mul", 3'b000, 32'd7, 32'hFFFFFFFD,
          32'hFFFFFFEB, 34);
    issue("mulh", 3'b001, 32'h80000000,
          32'h80000000, 32'h40000000, 34);
    issue("mulhsu", 3'b010, 32'h80000000,
          32'h80000000, 32'hC0000000, 34);
    issue("mulhu", 3'b011, 32'h80000000,
          32'h80000000, 32'h40000000, 34);
    issue("div", 3'b100, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFD, 34);
    issue("rem", 3'b110, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 34);
    issue("div_pos_neg", 3'b100, 32'd7, 32'hFFFFFFFE,
          32'hFFFFFFFD, 34);
    issue("rem_pos_neg", 3'b110, 32'd7, 32'hFFFFFFFE,
          32'd1, 34);
    issue("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    issue("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    issue("divu_by0", 3'b101, 32'd5, 32'd0,
          32'hFFFFFFFF, 1);
    issue("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    issue("div_ovf", 3'b100, 32'h80000000,
          32'hFFFFFFFF, 32'h80000000, 1);
    issue("rem_ovf", 3'b110, 32'h80000000,
          32'hFFFFFFFF, 32'd0, 1);

    // backpressure
    wait_ready();
    bus.res_ready = 1'b0;
    issue("mul_bp", 3'b000, 32'd6, 32'd7, 32'd42, 34);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result", bus.result, 32'd42);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;

    // kill and start together in IDLE
    wait_ready();
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    check("kill_start_busy", 32'(bus.busy), 32'd0);

    // kill at BUSY cycle 10
    issue("div_killed", 3'b101, 32'd1000, 32'd3,
          32'd0, 0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_kill_busy", 32'(bus.busy), 32'd1);
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill_busy", 32'(bus.busy), 32'd0);
    check("kill_req_ready", 32'(bus.req_ready), 32'd1);
    check("kill_res_valid", 32'(bus.res_valid), 32'd0);
    issue("mul_after_kill", 3'b000, 32'd3, 32'd4,
          32'd12, 34);

    // async reset mid-BUSY
    issue("mul_reset", 3'b000, 32'd9, 32'd9, 32'd0, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_req_ready",
          32'(bus.req_ready), 32'd1);
    check("mid_rst_res_valid",
          32'(bus.res_valid), 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue("mul_post_rst", 3'b000, 32'd2, 32'd2,
          32'd4, 34);

    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("sb_drained", sb.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
